// File: rtl/dm_cache_prefetch_ctrl.sv
// rtl/dm_cache_prefetch_ctrl.sv - trace-driven direct-mapped cache model with next-block prefetch
module dm_cache_prefetch_ctrl #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [15:0]      num_accesses,
    output logic             trace_start,
    input  logic             trace_done,
    input  logic [15:0]      next_trace,
    output logic             busy,
    output logic             finished,
    output logic [CNT_W-1:0] hits,
    output logic [CNT_W-1:0] misses,
    output logic [CNT_W-1:0] pf_hits,
    output logic [CNT_W-1:0] pf_issued
);

    localparam int TAG_W = 16 - INDEX_BITS - OFFSET_BITS;
    localparam int LINES = 1 << INDEX_BITS;
    localparam int BLK_W = 16 - OFFSET_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_LOOKUP, S_PREFETCH, S_NEXT, S_DONE
    } state_t;

    state_t state, state_nx;

    // Only the block number of the address matters; the word offset is dropped.
    logic [BLK_W-1:0]      blk_q;
    logic [15:0]           num_q;
    logic [15:0]           acc_cnt;
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      pf_q;
    logic [TAG_W-1:0]      tag_q [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tg;
    logic [BLK_W-1:0]      blk_nx;
    logic [INDEX_BITS-1:0] pf_idx;
    logic [TAG_W-1:0]      pf_tag;
    logic                  hit;
    logic                  pf_present;
    logic                  start_run;
    logic                  last_access;
    logic [OFFSET_BITS-1:0] unused_offset;

    assign unused_offset = next_trace[OFFSET_BITS-1:0];

    assign idx        = blk_q[INDEX_BITS-1:0];
    assign tg         = blk_q[BLK_W-1 -: TAG_W];
    assign blk_nx     = blk_q + {{(BLK_W-1){1'b0}}, 1'b1};
    assign pf_idx     = blk_nx[INDEX_BITS-1:0];
    assign pf_tag     = blk_nx[BLK_W-1 -: TAG_W];
    assign hit        = valid_q[idx] && (tag_q[idx] == tg);
    assign pf_present = valid_q[pf_idx] && (tag_q[pf_idx] == pf_tag);
    assign start_run  = run && (state == S_IDLE || state == S_DONE);
    assign last_access = (acc_cnt + 16'd1) == num_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nx    = state;
        trace_start = 1'b0;
        busy        = 1'b1;
        finished    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                busy     = 1'b0;
                finished = (state == S_DONE);
                if (start_run) state_nx = (num_accesses == 16'd0) ? S_DONE : S_REQ;
            end
            S_REQ: begin
                trace_start = 1'b1;
                state_nx    = S_WAIT;
            end
            S_WAIT:     if (trace_done) state_nx = S_LOOKUP;
            S_LOOKUP:   state_nx = hit ? S_NEXT : S_PREFETCH;
            S_PREFETCH: state_nx = S_NEXT;
            S_NEXT:     state_nx = last_access ? S_DONE : S_REQ;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Tag store, trace address, access count and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q     <= '0;
            num_q     <= '0;
            acc_cnt   <= '0;
            valid_q   <= '0;
            pf_q      <= '0;
            hits      <= '0;
            misses    <= '0;
            pf_hits   <= '0;
            pf_issued <= '0;
            for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_run) begin
                        num_q     <= num_accesses;
                        acc_cnt   <= '0;
                        valid_q   <= '0;
                        pf_q      <= '0;
                        hits      <= '0;
                        misses    <= '0;
                        pf_hits   <= '0;
                        pf_issued <= '0;
                    end
                end
                S_WAIT: begin
                    if (trace_done) blk_q <= next_trace[15:OFFSET_BITS];
                end
                S_LOOKUP: begin
                    if (hit) begin
                        hits <= sat_inc(hits);
                        if (pf_q[idx]) begin
                            pf_hits  <= sat_inc(pf_hits);
                            pf_q[idx] <= 1'b0;
                        end
                    end else begin
                        misses       <= sat_inc(misses);
                        valid_q[idx] <= 1'b1;
                        tag_q[idx]   <= tg;
                        pf_q[idx]    <= 1'b0;
                    end
                end
                S_PREFETCH: begin
                    if (!pf_present) begin
                        valid_q[pf_idx] <= 1'b1;
                        tag_q[pf_idx]   <= pf_tag;
                        pf_q[pf_idx]    <= 1'b1;
                        pf_issued       <= sat_inc(pf_issued);
                    end
                end
                S_NEXT: acc_cnt <= acc_cnt + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_prefetch_ctrl.sv
// tb/tb_dm_cache_prefetch_ctrl.sv - scoreboard bench for dm_cache_prefetch_ctrl
module tb_dm_cache_prefetch_ctrl;

    typedef struct {
        int hits;
        int misses;
        int pf_hits;
        int pf_issued;
        int starts;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] num_accesses = '0;
    logic        trace_start;
    logic        rd_done = 1'b0;
    logic        manual_done = 1'b0;
    logic        trace_done;
    logic [15:0] next_trace = '0;
    logic        busy, finished;
    logic [15:0] hits, misses, pf_hits, pf_issued;

    logic [15:0] trace_q [$];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          start_cnt = 0;
    bit          pend = 0;
    int          delay = 0;

    assign trace_done = rd_done | manual_done;

    always #5 clk = ~clk;

    dm_cache_prefetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run), .num_accesses(num_accesses),
        .trace_start(trace_start), .trace_done(trace_done), .next_trace(next_trace),
        .busy(busy), .finished(finished), .hits(hits), .misses(misses),
        .pf_hits(pf_hits), .pf_issued(pf_issued)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Trace reader: answers each trace_start with a trace_done after 0..2 idle cycles.
    initial begin
        forever begin
            @(negedge clk);
            rd_done = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else if (pend) begin
                if (delay == 0) begin
                    pend = 0;
                    rd_done = 1'b1;
                    if (trace_q.size() == 0) begin
                        check("trace_underrun", 1, 0);
                        next_trace = '0;
                    end else begin
                        next_trace = trace_q.pop_front();
                    end
                end else begin
                    delay--;
                end
            end else if (trace_start) begin
                start_cnt++;
                pend = 1;
                delay = $urandom_range(0, 2);
            end
        end
    end

    function automatic exp_t model(input logic [15:0] a [$]);
        exp_t e = '{0, 0, 0, 0, 0};
        bit         v [64];
        bit         p [64];
        logic [7:0] t [64];
        for (int i = 0; i < 64; i++) begin v[i] = 0; p[i] = 0; t[i] = '0; end
        foreach (a[i]) begin
            int         ix = int'(a[i][7:2]);
            logic [7:0] tg = a[i][15:8];
            logic [13:0] nb = a[i][15:2] + 14'd1;
            int         ni = int'(nb[5:0]);
            e.starts++;
            if (v[ix] && t[ix] == tg) begin
                e.hits++;
                if (p[ix]) begin e.pf_hits++; p[ix] = 0; end
            end else begin
                e.misses++;
                v[ix] = 1; t[ix] = tg; p[ix] = 0;
                if (!(v[ni] && t[ni] == nb[13:6])) begin
                    v[ni] = 1; t[ni] = nb[13:6]; p[ni] = 1;
                    e.pf_issued++;
                end
            end
        end
        return e;
    endfunction

    task automatic launch(input int n);
        num_accesses = 16'(n);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic do_run(input string name, input int n, input exp_t e);
        int   base = start_cnt;
        int   cyc = 0;
        exp_t x;
        sb.push_back(e);
        launch(n);
        while (!finished && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_timeout"}, int'(finished), 1);
        x = sb.pop_front();
        check({name, "_hits"}, int'(hits), x.hits);
        check({name, "_misses"}, int'(misses), x.misses);
        check({name, "_pf_hits"}, int'(pf_hits), x.pf_hits);
        check({name, "_pf_issued"}, int'(pf_issued), x.pf_issued);
        check({name, "_starts"}, start_cnt - base, x.starts);
        check({name, "_busy"}, int'(busy), 0);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_finished"}, int'(finished), 0);
        check({name, "_trace_start"}, int'(trace_start), 0);
        check({name, "_cnts"}, int'(hits | misses | pf_hits | pf_issued), 0);
    endtask

    initial begin
        logic [15:0] rq [$];
        exp_t e;
        int base, cyc;

        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        repeat (4) @(negedge clk);
        check_quiet("stray_done");
        check("stray_starts", start_cnt, 0);

        // num_accesses = 0 from IDLE: DONE right after the run edge, no request.
        base = start_cnt;
        launch(0);
        check("zero_finished", int'(finished), 1);
        check("zero_busy", int'(busy), 0);
        check("zero_starts", start_cnt - base, 0);

        trace_q = '{16'h0010};
        do_run("restart", 1, '{0, 1, 0, 1, 1});

        trace_q = '{16'h0000, 16'h0004, 16'h0008};
        do_run("seq", 3, '{1, 2, 1, 2, 3});

        trace_q = '{16'h0000, 16'h0100, 16'h0000};
        do_run("conflict", 3, '{0, 3, 0, 3, 3});

        trace_q = '{16'hFFFC, 16'h0000};
        do_run("wrap", 2, '{1, 1, 1, 1, 2});

        // Run issued while busy is ignored: second pulse mid-run leaves counts intact.
        trace_q = '{16'h0020, 16'h0024};
        sb.push_back('{1, 1, 1, 1, 2});
        base = start_cnt;
        launch(2);
        repeat (2) @(negedge clk);
        num_accesses = 16'd9;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        cyc = 0;
        while (!finished && cyc < 500) begin @(negedge clk); cyc++; end
        e = sb.pop_front();
        check("busyrun_finished", int'(finished), 1);
        check("busyrun_hits", int'(hits), e.hits);
        check("busyrun_misses", int'(misses), e.misses);
        check("busyrun_starts", start_cnt - base, e.starts);

        // Reset while waiting on the reader, then a clean rerun.
        trace_q = '{16'h0000, 16'h0004, 16'h0008, 16'h000C};
        base = start_cnt;
        launch(4);
        cyc = 0;
        while (start_cnt == base && cyc < 50) begin @(negedge clk); cyc++; end
        check("rst_first_start", start_cnt - base, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_quiet("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        trace_q.delete();
        repeat (3) @(negedge clk);
        check_quiet("after_reset");
        trace_q = '{16'h0000, 16'h0004, 16'h0008, 16'h000C};
        do_run("rerun", 4, '{2, 2, 2, 2, 4});

        // Random trace against the bench model.
        rq.delete();
        for (int i = 0; i < 24; i++) rq.push_back(16'($urandom_range(0, 1023)));
        rq.push_back(16'hFFFE);
        rq.push_back(16'h0001);
        trace_q = rq;
        do_run("random", rq.size(), model(rq));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_cache_prefetch_ctrl.md
# dm_cache_prefetch_ctrl

Trace-driven direct-mapped cache model with next-block prefetch. It sits directly downstream of the memory trace reader. It requests one 16-bit address per access with a `trace_start` pulse and samples the address on the reader's one-cycle `trace_done` pulse. Each address is looked up in an internal tag store, and the block accumulates hit, miss and prefetch statistics for the FPGA cache-simulator readout.

## Interface
Parameters:
- `INDEX_BITS`, 6: number of index bits; the cache has 2^INDEX_BITS lines.
- `OFFSET_BITS`, 2: block offset bits (4 words per block).
- `CNT_W`, 16: width of the statistics counters.
- Tag width is fixed at 16 − INDEX_BITS − OFFSET_BITS (8 bits at the defaults).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: starts a simulation run; sampled only in IDLE and DONE.
- `num_accesses` in 16: number of trace entries to consume; sampled when `run` is accepted.
- `trace_start` out 1: one-cycle request to the trace reader for the next entry.
- `trace_done` in 1: trace reader pulse; `next_trace` is valid in the same cycle.
- `next_trace` in 16: trace address.
- `busy` out 1: high in every state except IDLE and DONE.
- `finished` out 1: high while in DONE.
- `hits`, `misses`, `pf_hits`, `pf_issued` out CNT_W each: statistics counters.

## Operation
- Storage is flop-based, one entry per index: `valid`, `tag`, and `pf` (line was filled by prefetch and not yet demanded).
- Address split: offset = addr[OFFSET_BITS-1:0]; index = the next INDEX_BITS bits; tag = the remaining upper bits. Block number = addr >> OFFSET_BITS.
- FSM states:
  - IDLE: on `run`, latch `num_accesses` and clear all counters. In the same edge, clear every `valid` and `pf` bit and clear the access count. Go to REQ, or to DONE if `num_accesses` == 0.
  - REQ: assert `trace_start` for exactly one cycle, then go to WAIT.
  - WAIT: on `trace_done`, register `next_trace` and go to LOOKUP. `trace_done` seen in any other state is ignored; this covers the reader's power-up pulse.
  - LOOKUP: hit = valid[idx] && tag[idx] == addr tag.
    - On a hit: `hits`+1. If pf[idx] is set, also `pf_hits`+1 and clear pf[idx].
    - On a miss: `misses`+1; write valid=1, tag, pf=0 at idx; go to PREFETCH.
    - On a hit, go to NEXT.
  - PREFETCH: target block = block+1, modulo 2^(16−OFFSET_BITS), so 0xFFFC prefetches block 0. If the target is already present, do nothing. Otherwise write valid=1, the target tag and pf=1 at the target index (evicting any resident line), and increment `pf_issued`. Go to NEXT.
  - NEXT: increment the access count. If the count equals the latched `num_accesses`, go to DONE; otherwise go to REQ.
  - DONE: `finished`=1 and counters hold. `run` restarts exactly as from IDLE.
- The prefetch target index is always demand index+1 mod 2^INDEX_BITS, so it never evicts the line just filled.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- `run` asserted in busy states is ignored.

## Timing
- Reset values: state IDLE; `trace_start`=0, `busy`=0, `finished`=0; all counters 0; all valid/pf bits 0.
- Reset mid-run returns the block to IDLE immediately. Any in-flight reader transaction is abandoned, and its `trace_done` is ignored.
- Per-access latency:
  - Hit: REQ(1) + WAIT(≥1) + LOOKUP(1) + NEXT(1).
  - Miss: the same plus PREFETCH(1).
- Counters update at the LOOKUP or PREFETCH edge and are visible the following cycle.
- `finished` rises the cycle after the last NEXT.
- `trace_start` is never reasserted before `trace_done` has been received for the previous request.

## Test plan
- Reset with no `run`, then pulse `trace_done` → no `trace_start` is issued; all outputs stay 0.
- `run` with `num_accesses`=3 and trace 0x0000, 0x0004, 0x0008 → hits=1, misses=2, pf_hits=1, pf_issued=2, `finished`=1.
- Conflict trace 0x0000, 0x0100, 0x0000 → misses=3, hits=0, pf_issued=3.
- Wrap trace 0xFFFC, 0x0000 → misses=1, hits=1, pf_hits=1, pf_issued=1.
- `num_accesses`=0 → DONE one cycle after `run` with no `trace_start`. A second `run` with 1 access and 0x0010 → counters restart: misses=1, pf_issued=1.
- Assert `rst_n` low during WAIT of a 4-access run → all outputs return to reset values; a following `run` completes normally and the counts match a fresh run.
